// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 8;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BIT_CNT_W  = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_e;

  // Received byte plus its per-byte error flags, held in the output register.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              parity_err;
    logic              frame_err;
  } rx_word_t;

  // Oversample clock divider: truncated integer division, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    int unsigned d;
    d = clk_freq / (baud_rate * oversample);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle strobe every DIV clocks, restartable.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq   = 1000000,
  parameter int unsigned baud_rate  = 9600,
  parameter int unsigned oversample = OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV   = calc_div(clk_freq, baud_rate, oversample);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count and strobe; clr realigns the phase to the detected start edge.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver with parity/framing checks and a one-deep
// output register using a valid/ready handshake.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq   = 1000000,
  parameter int unsigned baud_rate  = 9600,
  parameter bit          parity_en  = 1'b0,
  parameter bit          parity_odd = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  // Line synchronizer and edge history; idle level is 1.
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic start_edge_c;

  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  rx_word_t             out_q, out_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic baud_tick;
  logic clr_c;
  logic stop_done_c;
  logic last_tick_c;

  uart_baud_tick #(
    .clk_freq   (clk_freq),
    .baud_rate  (baud_rate),
    .oversample (OVERSAMPLE)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_c),
    .tick (baud_tick)
  );

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign start_edge_c = rx_prev_q & ~rx_sync_q;
  assign last_tick_c  = baud_tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

  // Receive FSM next-state, datapath and output-register update.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    out_d       = out_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    clr_c       = 1'b0;
    stop_done_c = 1'b0;

    if (baud_tick && (state_q != S_IDLE) && (state_q != S_BREAK)) begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_edge_c) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          par_err_d  = 1'b0;
          clr_c      = 1'b1;
        end
      end
      S_START: begin
        if (baud_tick && (tick_cnt_q == TICK_W'(MID_TICK - 1))) begin
          if (!rx_sync_q) begin
            state_d    = S_DATA;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (last_tick_c) begin
          shift_d   = {rx_sync_q, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
            state_d = parity_en ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (last_tick_c) begin
          par_err_d = (((^shift_q) ^ rx_sync_q) != parity_odd);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (last_tick_c) begin
          stop_done_c = 1'b1;
          state_d     = rx_sync_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Load a finished byte if the holding register is free or draining now.
    if (stop_done_c) begin
      if (!rx_valid_q || rx_ready) begin
        out_d.data       = shift_q;
        out_d.parity_err = par_err_q;
        out_d.frame_err  = ~rx_sync_q;
        rx_valid_d       = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      out_q      <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      out_q      <= out_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data    = out_q.data;
  assign parity_err = out_q.parity_err;
  assign frame_err  = out_q.frame_err;
  assign rx_valid   = rx_valid_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 Parameter clk_freq, default 1000000, system clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600, line bit rate.
REQ-003 Parameter parity_en, default 0, 1 = a parity bit follows the data bits.
REQ-004 Parameter parity_odd, default 0, 1 = odd parity, 0 = even parity; ignored when parity_en=0.
REQ-005 Port clk, input, 1, single clock; all logic on posedge.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Port rx, input, 1, asynchronous serial line; idles high.
REQ-008 Port rx_data, output, 8, received byte, LSB first on the line.
REQ-009 Port rx_valid, output, 1, rx_data and the error flags are valid.
REQ-010 Port rx_ready, input, 1, consumer accepts; transfer occurs when rx_valid && rx_ready.
REQ-011 Port parity_err, output, 1, parity mismatch for the held byte; qualified by rx_valid.
REQ-012 Port frame_err, output, 1, stop bit sampled 0 for the held byte; qualified by rx_valid.
REQ-013 Port overrun, output, 1, one-cycle pulse when a completed byte is dropped.
REQ-014 Port busy, output, 1, high in every state except IDLE.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-016 The 16x tick SHALL come from a counter dividing by DIV = clk_freq/(baud_rate*16), integer-truncated with a minimum of 1; tick is a one-cycle strobe.
REQ-017 The tick divider SHALL restart at 0 on the cycle a start edge is detected, aligning sample phase to the edge.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-019 IDLE→START on a synchronized 1→0 transition; the tick counter is cleared.
REQ-020 In START, at tick 8 (mid start bit): rx=0 →DATA with the tick counter cleared; rx=1 →IDLE (glitch rejected, no output).
REQ-021 DATA SHALL sample rx every 16th tick, shifting into bit position 0..7 in order; after bit 7 →PARITY if parity_en=1, else →STOP.
REQ-022 PARITY SHALL sample one bit at its 16th tick; mismatch = (XOR of data ^ sampled bit) != parity_odd.
REQ-023 STOP SHALL sample at its 16th tick: rx=1 →IDLE; rx=0 →BREAK with frame_err set for this byte.
REQ-024 BREAK SHALL remain until synchronized rx=1, then →IDLE; no new start is detected while in BREAK.
REQ-025 On the stop sample, the byte and its flags SHALL load into the output register and rx_valid rises on the next cycle, provided rx_valid=0 or rx_ready=1 in that cycle.
REQ-026 If rx_valid=1 and rx_ready=0 at the stop sample, the new byte SHALL be discarded, overrun pulses for 1 cycle, and the held rx_data and flags stay unchanged.
REQ-027 rx_valid SHALL clear on handshake unless a new byte loads in the same cycle, in which case rx_valid stays 1 with the new data.
REQ-028 Frames with errors SHALL still be delivered, with their flags set.

Reset
REQ-029 When rst=0, all state SHALL clear asynchronously: FSM=IDLE, counters=0, rx_data=8'h00, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, synchronizer=1.
REQ-030 Reset mid-frame SHALL abandon the frame with no output; after release the block waits for a fresh falling edge.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum type, OVERSAMPLE=16, and the mid-bit constant 8.
REQ-032 The tick generator SHALL be sub-module uart_baud_tick (params clk_freq, baud_rate, oversample; ports clk, rst, clr, tick).

Verification (clk_freq=16000000, baud_rate=1000000 → DIV=1, 16 clk/bit)
REQ-033 Frame 0xA5, parity_en=0, rx_ready=1 → rx_data=8'hA5, rx_valid for 1 cycle, parity_err=0, frame_err=0.
REQ-034 4-clk low glitch on idle rx → no rx_valid, busy returns 0 by tick 8 plus synchronizer delay.
REQ-035 parity_en=1, parity_odd=0, byte 0x07 sent with parity bit 0 → rx_data=8'h07, parity_err=1; resent with parity bit 1 → parity_err=0.
REQ-036 Byte 0x3C with stop bit 0, line held low for 32 bits then high → frame_err=1 on 0x3C; next frame 0x55 received cleanly.
REQ-037 rx_ready=0, frames 0x11 then 0x22 → overrun pulses once, rx_data remains 8'h11; rx_ready=1 → single handshake.
REQ-038 rst pulled low during DATA bit 4 of 0xF0, then 0x0F sent after release → only 0x0F delivered.
